// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store.
// Data wins by default; a starvation counter forces fetch and a timeout abandons hung accesses.
module mem_port_arbiter #(
    parameter int WIDTH      = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    output logic             if_gnt,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_rvalid,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic             dm_gnt,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_rvalid,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             timeout_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t            state_reg, state_next;
    logic [SW-1:0]     starve_cnt_reg;
    logic [TW-1:0]     to_cnt_reg;
    logic              dm_we_reg;
    logic              timeout_err_reg;
    logic              busy;
    logic              timeout_hit;
    logic              done;
    logic [1:0]        port_own;
    logic [1:0]        port_load;
    logic [1:0]        rvalid_vec;
    logic [2*WIDTH-1:0] rdata_flat;

    assign busy        = (state_reg != IDLE);
    // An ack in the final BUSY cycle takes priority over the timeout.
    assign timeout_hit = busy && !mem_ack && (to_cnt_reg == TW'(TIMEOUT - 1));
    assign done        = busy && (mem_ack || timeout_hit);

    always_comb begin
        state_next = state_reg;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_reg)
            IDLE: begin
                if (!rst) begin
                    if (if_req && (!dm_req || starve_cnt_reg >= SW'(STARVE_MAX))) begin
                        if_gnt     = 1'b1;
                        mem_en     = 1'b1;
                        mem_addr   = if_addr;
                        state_next = BUSY_IF;
                    end else if (dm_req) begin
                        dm_gnt     = 1'b1;
                        mem_en     = 1'b1;
                        mem_we     = dm_we;
                        mem_addr   = dm_addr;
                        mem_wdata  = dm_wdata;
                        state_next = BUSY_DM;
                    end
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            starve_cnt_reg  <= '0;
            to_cnt_reg      <= '0;
            dm_we_reg       <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timeout_err_reg <= timeout_hit;
            if (if_gnt) begin
                starve_cnt_reg <= '0;
            end else if (dm_gnt && if_req && starve_cnt_reg < SW'(STARVE_MAX)) begin
                starve_cnt_reg <= starve_cnt_reg + SW'(1);
            end
            if (state_reg == IDLE) begin
                to_cnt_reg <= '0;
            end else begin
                to_cnt_reg <= to_cnt_reg + TW'(1);
            end
            if (dm_gnt) begin
                dm_we_reg <= dm_we;
            end
        end
    end

    // Port 0 is fetch, port 1 is load/store; stores never overwrite dm_rdata.
    assign port_own  = {state_reg == BUSY_DM, state_reg == BUSY_IF};
    assign port_load = {!dm_we_reg, 1'b1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [WIDTH-1:0] rdata_reg;
            logic             rvalid_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg  <= '0;
                    rvalid_reg <= 1'b0;
                end else begin
                    rvalid_reg <= port_own[gi] && done;
                    if (port_own[gi] && mem_ack && port_load[gi]) begin
                        rdata_reg <= mem_rdata;
                    end
                end
            end

            assign rdata_flat[gi*WIDTH +: WIDTH] = rdata_reg;
            assign rvalid_vec[gi]                = rvalid_reg;
        end
    endgenerate

    assign if_rdata    = rdata_flat[WIDTH-1:0];
    assign dm_rdata    = rdata_flat[2*WIDTH-1:WIDTH];
    assign if_rvalid   = rvalid_vec[0];
    assign dm_rvalid   = rvalid_vec[1];
    assign timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: fetch, store/load, starvation,
// timeout, ack-at-timeout, reset mid-transaction and back-to-back fetches.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic [31:0] if_rdata;
    logic        if_rvalid;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        timeout_err;

    int vectors    = 0;
    int miscompares = 0;

    mem_port_arbiter #(.WIDTH(32), .STARVE_MAX(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rdata(dm_rdata), .dm_rvalid(dm_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] order;
        rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;

        // Reset: requests during reset must not be granted
        tick(); tick();
        if_req = 1'b1; dm_req = 1'b1; settle();
        chk("rst_if_gnt", if_gnt, 0);
        chk("rst_dm_gnt", dm_gnt, 0);
        chk("rst_mem_en", mem_en, 0);
        tick();
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; settle();
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_dm_rvalid", dm_rvalid, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_idle_gnt", if_gnt, 0);

        // Single fetch
        if_req = 1'b1; if_addr = 32'h100; settle();
        chk("f_gnt", if_gnt, 1);
        chk("f_dm_gnt", dm_gnt, 0);
        chk("f_mem_en", mem_en, 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_we", mem_we, 0);
        chk("f_mem_wdata", mem_wdata, 0);
        tick();
        if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h00500093; settle();
        chk("f_busy_gnt", if_gnt, 0);
        chk("f_busy_en", mem_en, 0);
        chk("f_busy_rvalid", if_rvalid, 0);
        tick();
        mem_ack = 1'b0; settle();
        chk("f_rvalid", if_rvalid, 1);
        chk("f_rdata", if_rdata, 32'h00500093);
        chk("f_terr", timeout_err, 0);
        $display("txn fetch addr=00000100 rdata=%h", if_rdata);
        tick();
        chk("f_rvalid_pulse", if_rvalid, 0);

        // Store, then load back
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEADBEEF; settle();
        chk("st_gnt", dm_gnt, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_addr", mem_addr, 32'h40);
        chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        tick();
        dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h12345678; settle();
        tick();
        mem_ack = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_wdata = '0; settle();
        chk("st_rvalid", dm_rvalid, 1);
        chk("st_rdata_kept", dm_rdata, 0);
        chk("ld_gnt", dm_gnt, 1);
        chk("ld_mem_we", mem_we, 0);
        chk("ld_mem_addr", mem_addr, 32'h40);
        $display("txn store addr=00000040 wdata=deadbeef");
        tick();
        dm_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; settle();
        chk("ld_busy_rvalid", dm_rvalid, 0);
        tick();
        mem_ack = 1'b0; settle();
        chk("ld_rvalid", dm_rvalid, 1);
        chk("ld_rdata", dm_rdata, 32'hDEADBEEF);
        $display("txn load addr=00000040 rdata=%h", dm_rdata);

        // Starvation: D,D,D,D,I repeating (bit k set = fetch expected)
        order = 10'b10000_10000;
        if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk($sformatf("starve_if_gnt%0d", k), if_gnt, order[k]);
            chk($sformatf("starve_dm_gnt%0d", k), dm_gnt, !order[k]);
            $display("txn starve grant %0d %s", k, if_gnt ? "I" : "D");
            tick();
            mem_ack = 1'b1; mem_rdata = 32'hA0000000 | k; settle();
            tick();
            mem_ack = 1'b0;
        end
        if_req = 1'b0; dm_req = 1'b0; settle();
        chk("starve_last_ifv", if_rvalid, 1);
        chk("starve_if_rdata", if_rdata, 32'hA0000009);
        chk("starve_dm_rdata", dm_rdata, 32'hA0000008);

        // Timeout: load with no ack
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80; settle();
        chk("to_gnt", dm_gnt, 1);
        tick();
        dm_req = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            settle();
            chk($sformatf("to_wait%0d", c), dm_rvalid, 0);
            tick();
        end
        chk("to_rvalid", dm_rvalid, 1);
        chk("to_terr", timeout_err, 1);
        chk("to_rdata", dm_rdata, 32'hA0000008);
        $display("txn load addr=00000080 timeout");
        tick();
        chk("to_rvalid_pulse", dm_rvalid, 0);
        chk("to_terr_pulse", timeout_err, 0);
        tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h55555555; settle();
        tick();
        mem_ack = 1'b0; settle();
        chk("late_ack_dmv", dm_rvalid, 0);
        chk("late_ack_ifv", if_rvalid, 0);
        chk("late_ack_rdata", dm_rdata, 32'hA0000008);

        // Ack arriving in the final BUSY cycle wins over timeout
        if_req = 1'b1; if_addr = 32'h204; settle();
        chk("at_gnt", if_gnt, 1);
        tick();
        if_req = 1'b0;
        for (int c = 1; c < 16; c++) tick();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001; settle();
        tick();
        mem_ack = 1'b0; settle();
        chk("at_rvalid", if_rvalid, 1);
        chk("at_terr", timeout_err, 0);
        chk("at_rdata", if_rdata, 32'hCAFE0001);
        $display("txn fetch addr=00000204 rdata=%h (ack at limit)", if_rdata);
        tick();

        // Reset while in BUSY_IF
        if_req = 1'b1; if_addr = 32'h300; settle();
        chk("rm_gnt", if_gnt, 1);
        tick();
        rst = 1'b1; settle();
        chk("rm_in_rst_en", mem_en, 0);
        chk("rm_in_rst_gnt", if_gnt, 0);
        tick();
        rst = 1'b0; if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77777777; settle();
        chk("rm_ack_en", mem_en, 0);
        tick();
        mem_ack = 1'b0; settle();
        chk("rm_ifv", if_rvalid, 0);
        chk("rm_terr", timeout_err, 0);
        chk("rm_if_rdata", if_rdata, 0);
        chk("rm_dm_rdata", dm_rdata, 0);
        $display("txn fetch addr=00000300 abandoned by reset");

        // Back-to-back fetches 0x0, 0x4, 0x8
        if_req = 1'b1; if_addr = 32'h0; settle();
        chk("bb_gnt0", if_gnt, 1);
        chk("bb_addr0", mem_addr, 32'h0);
        tick();
        if_addr = 32'h4; mem_ack = 1'b1; mem_rdata = 32'h11; settle();
        chk("bb_busy0", if_gnt, 0);
        tick();
        mem_ack = 1'b0; settle();
        chk("bb_rv0", if_rvalid, 1);
        chk("bb_rd0", if_rdata, 32'h11);
        chk("bb_gnt1", if_gnt, 1);
        chk("bb_addr1", mem_addr, 32'h4);
        $display("txn fetch addr=00000000 rdata=%h", if_rdata);
        tick();
        if_addr = 32'h8; mem_ack = 1'b1; mem_rdata = 32'h22; settle();
        tick();
        mem_ack = 1'b0; settle();
        chk("bb_rv1", if_rvalid, 1);
        chk("bb_rd1", if_rdata, 32'h22);
        chk("bb_gnt2", if_gnt, 1);
        chk("bb_addr2", mem_addr, 32'h8);
        $display("txn fetch addr=00000004 rdata=%h", if_rdata);
        tick();
        if_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h33; settle();
        tick();
        mem_ack = 1'b0; settle();
        chk("bb_rv2", if_rvalid, 1);
        chk("bb_rd2", if_rdata, 32'h33);
        chk("bb_idle", if_gnt, 0);
        $display("txn fetch addr=00000008 rdata=%h", if_rdata);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported unified memory between the instruction-fetch requester and the load/store requester. It replaces the separate instruction and data memory paths once the core moves to a unified memory. It accepts one request at a time and issues it to the memory. It waits for the memory acknowledge, then returns read data to the owning requester. Data accesses win by default. A starvation counter guarantees fetch progress, and an acknowledge timeout prevents a hung memory from locking the core.

## Interface
- WIDTH, 32, data and address width
- STARVE_MAX, 4, consecutive data grants allowed while a fetch is pending before fetch is forced
- TIMEOUT, 16, cycles in a BUSY state without mem_ack before the transaction is abandoned
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- if_req  input  1  fetch request; held with if_addr stable until if_gnt
- if_addr  input  WIDTH  fetch address
- if_gnt  output  1  fetch accepted this cycle
- if_rdata  output  WIDTH  registered fetch data
- if_rvalid  output  1  one-cycle pulse: if_rdata valid / fetch complete
- dm_req  input  1  data request; held with dm_we/dm_addr/dm_wdata stable until dm_gnt
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  WIDTH  data address
- dm_wdata  input  WIDTH  store data
- dm_gnt  output  1  data request accepted this cycle
- dm_rdata  output  WIDTH  registered load data
- dm_rvalid  output  1  one-cycle pulse: load data valid or store complete
- mem_en  output  1  memory command strobe, one cycle per transaction
- mem_we  output  1  write command
- mem_addr  output  WIDTH  memory address
- mem_wdata  output  WIDTH  memory write data
- mem_rdata  input  WIDTH  memory read data, valid with mem_ack
- mem_ack  input  1  transaction complete, one-cycle pulse
- timeout_err  output  1  one-cycle pulse with the rvalid of an abandoned transaction

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE arbitration is combinational in the same cycle:
  - Fetch wins if `if_req && (!dm_req || starve_cnt >= STARVE_MAX)`.
  - Otherwise data wins if dm_req.
  - If neither is requesting, nothing is granted and the state stays IDLE.
- Grant cycle:
  - Exactly one gnt is high and mem_en=1.
  - mem_addr, mem_we and mem_wdata are driven from the winner; a fetch forces mem_we=0 and mem_wdata=0.
  - The next state is BUSY_IF or BUSY_DM.
- Outside a grant cycle: mem_en, mem_we, mem_addr, mem_wdata and both gnts are 0.
- starve_cnt has width $clog2(STARVE_MAX+1).
  - Increments, saturating, on a data grant while if_req=1.
  - Clears on a fetch grant.
  - Otherwise holds.
- BUSY_x behaviour:
  - Counts cycles in to_cnt, which is cleared on entry.
  - On mem_ack: latch mem_rdata into the owner's rdata register. This happens for loads and fetches only; a store leaves dm_rdata unchanged. Pulse the owner's rvalid next cycle and return to IDLE.
  - If to_cnt reaches TIMEOUT-1 with no ack: return to IDLE, pulse the owner's rvalid and timeout_err next cycle, and leave rdata unchanged.
- mem_ack in IDLE is ignored, including a late ack after a timeout.
- Requesters may drop req only after gnt. A request dropped before gnt is simply not serviced.

## Timing
- Reset values:
  - State IDLE; starve_cnt=0; to_cnt=0.
  - if_rdata=0, dm_rdata=0; if_rvalid=0, dm_rvalid=0, timeout_err=0.
  - Combinational outputs are forced 0 while rst=1.
- A reset mid-transaction abandons it with no rvalid. A mem_ack arriving during or after reset is ignored.
- Minimum transaction:
  - Grant in cycle N.
  - mem_ack earliest in cycle N+1.
  - rvalid in cycle N+2, which is also an IDLE cycle, so a new grant can issue in N+2.
  - Sustained throughput is one transaction per 2 cycles with single-cycle memory.
- Latency from grant to rvalid is memory latency + 1 cycle.
- Timeout:
  - With no ack, BUSY lasts TIMEOUT cycles.
  - rvalid and timeout_err appear TIMEOUT+1 cycles after the grant.
- mem_ack and timeout in the same cycle: ack wins, with no timeout_err.
- Simultaneous if_req and dm_req with starve_cnt < STARVE_MAX: data is granted.
  - With fetch held continuously and data requesting continuously, the sequence is STARVE_MAX data grants, then 1 fetch grant, repeating.

## Test plan
- Single fetch: if_req=1, if_addr=0x100; mem_ack one cycle after grant with mem_rdata=0x00500093 -> if_gnt in cycle 0, mem_en=1 and mem_addr=0x100 in cycle 0, if_rvalid=1 and if_rdata=0x00500093 in cycle 2.
- Store then load: dm store to addr 0x40 with data 0xDEADBEEF, then a load from 0x40 with memory returning 0xDEADBEEF.
  - Store: mem_we=1 on the grant cycle, and dm_rvalid pulses with dm_rdata still 0.
  - Load: dm_rdata=0xDEADBEEF.
- Starvation, STARVE_MAX=4: if_req and dm_req held high with 1-cycle acks -> grant order D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I.
- Timeout, TIMEOUT=16: data load with no ack -> dm_rvalid=1 and timeout_err=1 exactly 17 cycles after dm_gnt. A late mem_ack 3 cycles later produces no rvalid.
- Reset mid-operation: assert rst for 1 cycle while in BUSY_IF, then send mem_ack -> no if_rvalid, all outputs 0, and the next if_req is granted in its first cycle.
- Back-to-back: queued fetches to 0x0, 0x4, 0x8 with 1-cycle acks -> if_gnt in cycles 0, 2 and 4; if_rvalid in cycles 2, 4 and 6.
